p2s_stream: RTL and testbench
=============================

P2S_STREAM -- requirements
Module: p2s_stream

Interface
REQ-001 SHALL have parameter WIDTH, default 8: parallel word width in bits; legal values 2..64.
REQ-002 SHALL have parameter LSB_FIRST, default 1: 1 serialises bit 0 first, 0 serialises bit WIDTH-1 first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port d_in, input, WIDTH bits: parallel word to serialise.
REQ-006 SHALL have port load, input, 1 bit: load request; qualifies d_in.
REQ-007 SHALL have port ready, output, 1 bit: block accepts a load this cycle.
REQ-008 SHALL have port shift, input, 1 bit: advance enable; when low, serial output stalls.
REQ-009 SHALL have port d_out, output, 1 bit: serial data, registered.
REQ-010 SHALL have port d_out_valid, output, 1 bit: d_out carries a new bit this cycle, registered.
REQ-011 SHALL have port last, output, 1 bit: current d_out bit is the final bit of the frame, registered.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress (not IDLE).

Function
REQ-013 SHALL implement the FSM states IDLE, SHIFT and, when parity is compiled in, PARITY.
REQ-014 SHALL drive ready = (state == IDLE), combinationally; busy = !ready.
REQ-015 SHALL, in IDLE with load=1, capture d_in into the shift register, clear the bit counter and go to SHIFT; no bit is emitted in the capture cycle.
REQ-016 SHALL ignore load while busy: no capture, no effect on the frame in progress.
REQ-017 SHALL, in SHIFT on an edge with shift=1, register the next bit in the LSB_FIRST order into d_out, set d_out_valid=1 and increment the counter.
REQ-018 SHALL, in SHIFT on an edge with shift=0, hold d_out and the counter and set d_out_valid=0 (stall; no bit is lost or duplicated).
REQ-019 SHALL have a bit counter of width $clog2(WIDTH+1); it never exceeds WIDTH.
REQ-020 SHALL, on the shift edge emitting bit WIDTH-1 of the sequence, go to IDLE and set last=1 when parity is compiled out, or go to PARITY with last=0 when it is compiled in.
REQ-021 SHALL hold last=0 except in the cycle following the final-bit edge; d_out_valid=0 in IDLE.
REQ-022 SHALL hold d_out at its last value after a frame ends, until the next emitted bit or reset.
REQ-023 SHALL, with load held high continuously, start a new frame exactly one cycle after returning to IDLE (one idle cycle between frames).
REQ-024 SHALL treat shift in IDLE as a no-op.
REQ-025 SHALL treat load and shift asserted together as load-only in IDLE and shift-only in SHIFT/PARITY, never producing an X.

Reset
REQ-026 SHALL, on rst, asynchronously force state=IDLE, the counter and shift register to 0, and d_out=0, d_out_valid=0, last=0; this gives ready=1 and busy=0.
REQ-027 SHALL, on rst asserted mid-frame, abort the frame with no further bits emitted; the first load after rst deasserts starts a fresh frame.

Configuration
REQ-028 SHALL use the macro P2S_STREAM_PARITY_EN to select parity support.
REQ-029 SHALL, when the macro is defined, capture the even parity (XOR of d_in) at load, and in PARITY on a shift=1 edge emit it with d_out_valid=1 and last=1, then go to IDLE; a stall behaves as in REQ-018.
REQ-030 SHALL, when the macro is undefined, have no PARITY state or parity logic; frames are exactly WIDTH bits.

Structure
REQ-031 SHALL take the FSM state enum and the state encodings (IDLE=0, SHIFT=1, PARITY=2) from the shared package p2s_pkg.
REQ-032 SHALL use one sub-module, p2s_bit_cnt: a parametrised counter with clear, enable and terminal-count output; all other logic is in p2s_stream.

Verification
REQ-033 SHALL cover: WIDTH=8, LSB_FIRST=1, load 0xA5, shift held high -> d_out 1,0,1,0,0,1,0,1 on 8 consecutive cycles, last on the 8th, ready=1 the next cycle.
REQ-034 SHALL cover: LSB_FIRST=0, load 0xA5 -> d_out 1,0,1,0,0,1,0,1 (MSB first); load 0x80 -> 1 then seven 0s.
REQ-035 SHALL cover: load 0x0F, shift low for 3 cycles after the 2nd bit -> d_out_valid=0 and d_out=1 held during the stall, remaining bits resume with none lost.
REQ-036 SHALL cover: load 0x3C held high through the frame with d_in changed to 0xFF -> frame still 0x3C; next frame 0xFF after one idle cycle.
REQ-037 SHALL cover: rst pulsed after the 4th bit of 0xA5 -> outputs 0 immediately, ready=1; a subsequent load of 0x01 gives a clean 8-bit frame.
REQ-038 SHALL cover, with the macro defined: load 0xA5 -> 9th bit 0 with last=1; load 0x07 -> 9th bit 1 with last=1.

Source files
------------

// File: rtl/p2s_pkg.sv
// Shared types for the p2s_stream serialiser.
// The PARITY state exists only when P2S_STREAM_PARITY_EN is defined.
package p2s_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1
`ifdef P2S_STREAM_PARITY_EN
    ,PARITY = 2'd2
`endif
  } p2s_state_e;

  // Counter width able to hold the values 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/p2s_bit_cnt.sv
// Bit counter for p2s_stream: synchronous clear, count enable, and a
// terminal flag that is high while the next enabled count is the final bit.
module p2s_bit_cnt
  import p2s_pkg::*;
#(
  parameter int MAX = 8,
  parameter int CW  = cnt_width(MAX)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Saturates at MAX so the count can never run past the frame length.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(MAX))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CW'(MAX - 1));

endmodule

// File: rtl/p2s_stream.sv
// Parallel-to-serial stream converter with load/shift handshake.
// Define P2S_STREAM_PARITY_EN to append an even-parity bit to every frame.
module p2s_stream
  import p2s_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load,
  output logic             ready,
  input  logic             shift,
  output logic             d_out,
  output logic             d_out_valid,
  output logic             last,
  output logic             busy
);

  p2s_state_e       state_q;
  logic [WIDTH-1:0] sreg_q;
  logic             d_out_q;
  logic             valid_q;
  logic             last_q;
`ifdef P2S_STREAM_PARITY_EN
  logic             parity_q;
`endif

  logic             final_bit;
  logic             cnt_clr;
  logic             cnt_en;
  logic             next_bit;
  logic [WIDTH-1:0] sreg_next;

  assign ready   = (state_q == IDLE);
  assign busy    = !ready;
  assign cnt_clr = ready && load;
  assign cnt_en  = (state_q == SHIFT) && shift;

  assign next_bit  = LSB_FIRST ? sreg_q[0] : sreg_q[WIDTH-1];
  assign sreg_next = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);

  p2s_bit_cnt #(
    .MAX (WIDTH)
  ) u_bit_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (final_bit)
  );

  // valid/last are single-cycle pulses; d_out keeps its value between bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sreg_q   <= '0;
      d_out_q  <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
`ifdef P2S_STREAM_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            sreg_q   <= d_in;
`ifdef P2S_STREAM_PARITY_EN
            parity_q <= ^d_in;
`endif
            state_q  <= SHIFT;
          end
        end
        SHIFT: begin
          if (shift) begin
            d_out_q <= next_bit;
            sreg_q  <= sreg_next;
            valid_q <= 1'b1;
            if (final_bit) begin
`ifdef P2S_STREAM_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= IDLE;
              last_q  <= 1'b1;
`endif
            end
          end
        end
`ifdef P2S_STREAM_PARITY_EN
        PARITY: begin
          if (shift) begin
            d_out_q <= parity_q;
            valid_q <= 1'b1;
            last_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign d_out       = d_out_q;
  assign d_out_valid = valid_q;
  assign last        = last_q;

endmodule

// File: tb/tb_p2s_stream.sv
// Self-checking bench for p2s_stream: an LSB-first and an MSB-first instance
// share stimulus; a queue-based frame model checks every cycle.
module tb_p2s_stream;

  localparam int W = 8;
`ifdef P2S_STREAM_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk;
  logic         rst;
  logic         load;
  logic         shift;
  logic [W-1:0] dIn;

  logic lsbDout, lsbValid, lsbLast, lsbReady, lsbBusy;
  logic msbDout, msbValid, msbLast, msbReady, msbBusy;

  p2s_stream #(.WIDTH(W), .LSB_FIRST(1'b1)) dutLsb (
    .clk(clk), .rst(rst), .d_in(dIn), .load(load), .ready(lsbReady),
    .shift(shift), .d_out(lsbDout), .d_out_valid(lsbValid),
    .last(lsbLast), .busy(lsbBusy)
  );

  p2s_stream #(.WIDTH(W), .LSB_FIRST(1'b0)) dutMsb (
    .clk(clk), .rst(rst), .d_in(dIn), .load(load), .ready(msbReady),
    .shift(shift), .d_out(msbDout), .d_out_valid(msbValid),
    .last(msbLast), .busy(msbBusy)
  );

  int nAssert;
  int nFail;

  // Reference model: a frame is a queue of bits in emission order.
  logic qLsb[$];
  logic qMsb[$];
  logic mBusy, mDoutL, mDoutM, mValid, mLast;

  // lsbSeq/msbSeq: bit i is the i-th emitted bit; par is the parity bit.
  typedef struct {
    logic [7:0] data;
    logic [7:0] lsbSeq;
    logic [7:0] msbSeq;
    logic       par;
  } vec_t;
  vec_t vecs[6];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string name, input logic act, input logic exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpInt(input string name, input int act, input int exp);
    nAssert++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    qLsb.delete();
    qMsb.delete();
    mBusy  = 1'b0;
    mDoutL = 1'b0;
    mDoutM = 1'b0;
    mValid = 1'b0;
    mLast  = 1'b0;
  endtask

  task automatic modelEdge();
    if (rst) begin
      modelReset();
    end else if (!mBusy) begin
      mValid = 1'b0;
      mLast  = 1'b0;
      if (load) begin
        for (int i = 0; i < W; i++) begin
          qLsb.push_back(dIn[i]);
          qMsb.push_back(dIn[W-1-i]);
        end
`ifdef P2S_STREAM_PARITY_EN
        qLsb.push_back(^dIn);
        qMsb.push_back(^dIn);
`endif
        mBusy = 1'b1;
      end
    end else if (shift) begin
      mDoutL = qLsb.pop_front();
      mDoutM = qMsb.pop_front();
      mValid = 1'b1;
      mLast  = (qLsb.size() == 0);
      if (mLast) mBusy = 1'b0;
    end else begin
      mValid = 1'b0;
      mLast  = 1'b0;
    end
  endtask

  task automatic checkOutput();
    cmp("lsb d_out", lsbDout, mDoutL);
    cmp("lsb d_out_valid", lsbValid, mValid);
    cmp("lsb last", lsbLast, mLast);
    cmp("lsb ready", lsbReady, !mBusy);
    cmp("lsb busy", lsbBusy, mBusy);
    cmp("msb d_out", msbDout, mDoutM);
    cmp("msb d_out_valid", msbValid, mValid);
    cmp("msb last", msbLast, mLast);
    cmp("msb ready", msbReady, !mBusy);
    cmp("msb busy", msbBusy, mBusy);
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  // Load one word and stream it with shift held high, checking the fixed table.
  task automatic runVector(input vec_t v);
    logic expL, expM;
    dIn   = v.data;
    load  = 1'b1;
    shift = 1'b0;
    applyStimulus();
    cmp("table busy after load", lsbBusy, 1'b1);
    load  = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < FL; i++) begin
      applyStimulus();
      expL = (i < W) ? v.lsbSeq[i] : v.par;
      expM = (i < W) ? v.msbSeq[i] : v.par;
      cmp("table lsb bit", lsbDout, expL);
      cmp("table msb bit", msbDout, expM);
      cmp("table valid", lsbValid, 1'b1);
      cmp("table last", lsbLast, (i == FL - 1));
    end
    shift = 1'b0;
    cmp("table ready after frame", lsbReady, 1'b1);
  endtask

  task automatic stallSequence();
    logic [7:0] word;
    word  = '0;
    dIn   = 8'h0F;
    load  = 1'b1;
    applyStimulus();
    load  = 1'b0;
    shift = 1'b1;
    for (int i = 0; i < 2; i++) begin
      applyStimulus();
      word[i] = lsbDout;
    end
    shift = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus();
      cmp("stall valid", lsbValid, 1'b0);
      cmp("stall lsb d_out held", lsbDout, 1'b1);
      cmp("stall msb d_out held", msbDout, 1'b0);
    end
    shift = 1'b1;
    for (int i = 2; i < FL; i++) begin
      applyStimulus();
      if (i < W) word[i] = lsbDout;
    end
    shift = 1'b0;
    cmpInt("stall frame word", int'(word), 32'h0F);
    cmp("stall ready after frame", lsbReady, 1'b1);
  endtask

  task automatic loadHeldSequence();
    logic bits[2*FL];
    int nb;
    logic [7:0] w1, w2;
    nb = 0;
    for (int i = 0; i < 2 * FL; i++) bits[i] = 1'b0;
    dIn   = 8'h3C;
    load  = 1'b1;
    shift = 1'b1;
    applyStimulus();
    dIn = 8'hFF;
    for (int k = 0; k < 2 * FL + 1; k++) begin
      applyStimulus();
      if (k == FL) cmp("idle gap valid", lsbValid, 1'b0);
      if (lsbValid && nb < 2 * FL) begin
        bits[nb] = lsbDout;
        nb++;
      end
    end
    load  = 1'b0;
    shift = 1'b0;
    for (int i = 0; i < W; i++) begin
      w1[i] = bits[i];
      w2[i] = bits[FL+i];
    end
    cmpInt("held-load bit count", nb, 2 * FL);
    cmpInt("held-load frame 1", int'(w1), 32'h3C);
    cmpInt("held-load frame 2", int'(w2), 32'hFF);
  endtask

  task automatic resetSequence();
    dIn   = 8'hA5;
    load  = 1'b1;
    applyStimulus();
    load  = 1'b0;
    shift = 1'b1;
    repeat (4) applyStimulus();
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput();
    cmp("async reset d_out", lsbDout, 1'b0);
    cmp("async reset ready", lsbReady, 1'b1);
    shift = 1'b0;
    applyStimulus();
    rst = 1'b0;
    runVector(vecs[5]);
  endtask

  initial begin
    nAssert = 0;
    nFail   = 0;
    vecs[0] = '{8'hA5, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h80, 8'h80, 8'h01, 1'b1};
    vecs[2] = '{8'h07, 8'h07, 8'hE0, 1'b1};
    vecs[3] = '{8'h0F, 8'h0F, 8'hF0, 1'b0};
    vecs[4] = '{8'h3C, 8'h3C, 8'h3C, 1'b0};
    vecs[5] = '{8'h01, 8'h01, 8'h80, 1'b1};

    rst   = 1'b1;
    load  = 1'b0;
    shift = 1'b0;
    dIn   = '0;
    modelReset();
    applyStimulus();
    applyStimulus();
    cmp("reset ready", lsbReady, 1'b1);
    cmp("reset busy", msbBusy, 1'b0);
    rst = 1'b0;

    shift = 1'b1;
    applyStimulus();
    applyStimulus();
    shift = 1'b0;

    for (int v = 0; v < 6; v++) runVector(vecs[v]);

    stallSequence();
    loadHeldSequence();
    resetSequence();

    for (int n = 0; n < 400; n++) begin
      load  = ($urandom_range(0, 3) == 0);
      shift = ($urandom_range(0, 3) != 0);
      dIn   = W'($urandom);
      applyStimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
